fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the PC into the combinational, word-indexed instruction memory.
- Captures each returned machine code word, with its PC, into a 2-entry fetch buffer.
- Presents buffered instructions to decode over a valid/ready handshake.
- Handles pipeline redirects (branch/jump), end-of-program detection and fetch faults.

Parameters:
- RESET_PC, 32'h0000_0004: first fetch address after reset.
- IMEM_DEPTH, 32: instruction memory size in 32-bit words. Legal fetch addresses are 0 .. 4*IMEM_DEPTH-4.
- BUF_DEPTH, 2: fetch buffer entries. Only 2 is required to be supported.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable_i  in  1  permits fetching.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  32  redirect target.
- imem_addr  out  32  byte address to instruction memory. Memory indexes with addr>>2.
- imem_data  in  32  machine code returned combinationally for imem_addr.
- inst_valid  out  1  head buffer entry valid.
- inst_ready  in  1  decode accepts head entry.
- inst_pc  out  32  PC of head entry.
- inst_word  out  32  machine code of head entry.
- halted  out  1  fetch stopped (end-of-program or fault).
- fetch_fault  out  1  stopped because of a bad fetch address.

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, state=IDLE, count=0, buffer entries=0. Outputs: inst_valid=0, inst_pc=0, inst_word=0, halted=0, fetch_fault=0, imem_addr=RESET_PC. Reset mid-operation discards all buffered entries immediately.
- imem_addr = fetch_pc, combinational from register. imem_data is sampled in the same cycle.
- inst_valid = (count!=0). inst_pc and inst_word come from the head entry and are 0 when empty. All are register-driven, with no combinational path from imem_data.
- pop = inst_valid & inst_ready.
- push condition: state==RUN & enable_i & !redirect_valid & (count<BUF_DEPTH | pop) & imem_data!=0 & addr_ok.
- addr_ok: fetch_pc[1:0]==0 and (fetch_pc>>2) < IMEM_DEPTH.
- On push: write {fetch_pc, imem_data} to tail and set fetch_pc += 4, wrapping modulo 2^32.
- Push and pop in the same cycle with count==BUF_DEPTH is allowed; count stays unchanged.
- States:
  - IDLE -> RUN on a rising edge where enable_i=1. No push on that edge. The first inst_valid therefore rises 2 edges after enable_i is first sampled high.
  - RUN with enable_i=0: no push, buffer continues to drain, state stays RUN.
  - RUN -> HALT when fetch is attempted (enable_i=1, no redirect, space available):
    - !addr_ok: halted=1, fetch_fault=1, no push.
    - imem_data==32'h0 (end-of-program marker): halted=1, fetch_fault=0, no push.
  - HALT: no fetches. Buffer keeps draining via pop. Left only by reset or redirect.
- Redirect (any state except during reset):
  - Highest priority.
  - Flushes the buffer (count=0) and sets fetch_pc=redirect_pc.
  - halted=0 and fetch_fault=0; state=RUN.
  - A pop in the same cycle is not a transfer; decode must treat it as killed.
  - If redirect_pc is misaligned or out of range, the next fetch attempt faults per the rule above.
- Simultaneous redirect + push-eligible cycle: redirect wins and nothing is pushed.
- Buffer ordering is strict FIFO. No entry is duplicated or lost under any inst_ready pattern.
- fetch_pc holds while the buffer is full and there is no pop.

Test Plan:
- Reset, enable_i=1, inst_ready=1, mem[1]=0x123450b7, mem[2]=0x12345117, mem[3]=0x00a00113 -> inst_valid rises on 2nd edge after enable. Accepted sequence is (0x4,0x123450b7), (0x8,0x12345117), (0xC,0x00a00113), one per cycle.
- inst_ready=0 after start -> count reaches 2 holding PCs 0x4 and 0x8, imem_addr frozen at 0xC. Raise inst_ready -> 0x4, 0x8, 0xC delivered in order with no gap or duplicate.
- Buffer full (0x4, 0x8), redirect_valid=1 with redirect_pc=0x18, inst_ready=1 same cycle -> next cycle inst_valid=0, then (0x18, mem[6]); the 0x4 handshake does not count as a transfer.
- mem[12]=0 with sequential run from 0x4 -> last delivered PC is 0x2C, halted=1, fetch_fault=0, imem_addr holds 0x30, buffer drains then inst_valid=0.
- redirect_pc=0x6 -> halted=1, fetch_fault=1, nothing pushed. redirect_pc=0x80 (IMEM_DEPTH=32) -> same result. Then redirect_pc=0x4 -> both flags clear and (0x4,0x123450b7) is delivered.
- rst_n pulled low asynchronously mid-run with count=2 -> inst_valid, halted, fetch_fault and inst_word go 0 immediately without a clock edge, and imem_addr=0x4.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks the PC through a combinational word-indexed
// instruction memory and buffers {pc, word} pairs in a small FIFO for decode.
// Latency: first inst_valid two edges after enable_i is sampled high.
// Backpressure: inst_ready low fills the buffer, and fetch_pc then holds.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0004,
  parameter int          IMEM_DEPTH = 32,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_word,
  output logic        halted,
  output logic        fetch_fault
);

  localparam int          CW         = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] BUF_FULL = CW'(BUF_DEPTH);
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  entry_t        fb_q [BUF_DEPTH];
  entry_t        fb_d [BUF_DEPTH];

  logic pop;
  logic addr_ok;
  logic attempt;
  logic push;

  // Handshake and fetch-eligibility decode; a full buffer still accepts a fetch when the head pops.
  always_comb begin
    pop     = (count_q != '0) & inst_ready;
    addr_ok = (fetch_pc_q[1:0] == 2'b00) && ((fetch_pc_q >> 2) < IMEM_LIMIT);
    attempt = (state_q == S_RUN) & enable_i & ~redirect_valid & ((count_q < BUF_FULL) | pop);
    push    = attempt & addr_ok & (imem_data != '0);
  end

  // Fetch buffer as a shift FIFO: entry 0 is always the head, vacated slots are zeroed.
  always_comb begin
    fb_d    = fb_q;
    count_d = count_q;
    if (redirect_valid) begin
      for (int i = 0; i < BUF_DEPTH; i++) fb_d[i] = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) fb_d[i] = fb_q[i+1];
        fb_d[BUF_DEPTH-1] = '0;
        count_d = count_q - CW'(1);
      end
      if (push) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
          if (CW'(i) == count_d) fb_d[i] = '{pc: fetch_pc_q, word: imem_data};
        end
        count_d = count_d + CW'(1);
      end
    end
  end

  // Sequencing control: redirect overrides everything, HALT only leaves via redirect or reset.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    if (redirect_valid) begin
      state_d    = S_RUN;
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
      fault_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (enable_i) state_d = S_RUN;
        S_RUN: begin
          if (attempt) begin
            if (!addr_ok) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              fault_d  = 1'b1;
            end else if (imem_data == '0) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              fetch_pc_d = fetch_pc_q + 32'd4;
            end
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, PC, flags and buffer registers; reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) fb_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      for (int i = 0; i < BUF_DEPTH; i++) fb_q[i] <= fb_d[i];
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign inst_valid  = (count_q != '0);
  assign inst_pc     = fb_q[0].pc;
  assign inst_word   = fb_q[0].word;
  assign halted      = halted_q;
  assign fetch_fault = fault_q;

endmodule
